// File: rtl/ysyx_040729_idu_operand_stage_if.sv
// Decoder-to-EXU handshake bundle for the operand-fetch stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface ysyx_040729_idu_operand_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_READ   = 2,
  parameter int PAYLOAD_W  = 32
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_READ-1:0]              in_ren;
  logic [NUM_READ*REG_ADDR_W-1:0]   in_raddr;
  logic [PAYLOAD_W-1:0]             in_payload;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_READ*DATA_WIDTH-1:0]   out_rdata;
  logic [PAYLOAD_W-1:0]             out_payload;

  modport master (
    output in_valid, in_ren, in_raddr,
    output in_payload, out_ready,
    input  in_ready, out_valid,
    input  out_rdata, out_payload
  );

  modport slave (
    input  in_valid, in_ren, in_raddr,
    input  in_payload, out_ready,
    output in_ready, out_valid,
    output out_rdata, out_payload
  );
endinterface

// File: rtl/ysyx_040729_idu_operand_stage.sv
// Operand fetch: regfile, multi-stage forwarding, load-use hazard,
// registered ID->EX output with valid/ready and a saturating stall counter.
module ysyx_040729_idu_operand_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_READ   = 2,
  parameter int FWD_STAGES = 2,
  parameter int PAYLOAD_W  = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  ysyx_040729_idu_operand_stage_if.slave   bus,
  input  logic [FWD_STAGES-1:0]            fwd_we,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_data,
  input  logic [FWD_STAGES-1:0]            fwd_data_ok,
  input  logic                             wb_we,
  input  logic [REG_ADDR_W-1:0]            wb_waddr,
  input  logic [DATA_WIDTH-1:0]            wb_wdata,
  output logic                             hazard_o,
  output logic [31:0]                      stall_cnt_o
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_WIDTH-1:0]           rf [NREG];
  logic [REG_ADDR_W-1:0]           raddr [NUM_READ];
  logic [NUM_READ*DATA_WIDTH-1:0]  opnd;
  logic [NUM_READ-1:0]             port_haz;
  logic [NUM_READ-1:0]             fwd_hit;
  logic                            any_haz;
  logic                            fire;

  logic                            out_valid_q;
  logic [NUM_READ*DATA_WIDTH-1:0]  rdata_q;
  logic [PAYLOAD_W-1:0]            payload_q;
  logic [31:0]                     stall_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_waddr != '0) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_raddr
    assign raddr[p] = bus.in_raddr[p*REG_ADDR_W +: REG_ADDR_W];
  end

  // Descending scan so the youngest matching stage is the last to write.
  always_comb begin
    opnd     = '0;
    port_haz = '0;
    fwd_hit  = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (bus.in_ren[p] && raddr[p] != '0) begin
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
          if (fwd_we[k] &&
              fwd_addr[k*REG_ADDR_W +: REG_ADDR_W] == raddr[p]) begin
            fwd_hit[p] = 1'b1;
            opnd[p*DATA_WIDTH +: DATA_WIDTH] =
              fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
            port_haz[p] = ~fwd_data_ok[k];
          end
        end
        if (!fwd_hit[p]) begin
          if (wb_we && wb_waddr == raddr[p])
            opnd[p*DATA_WIDTH +: DATA_WIDTH] = wb_wdata;
          else
            opnd[p*DATA_WIDTH +: DATA_WIDTH] = rf[raddr[p]];
        end
      end
    end
  end

  // in_ready uses the ungated hazard so it never depends on in_valid.
  assign any_haz      = |port_haz;
  assign hazard_o     = bus.in_valid & any_haz;
  assign bus.in_ready = ~flush & ~any_haz &
                        (~out_valid_q | bus.out_ready);
  assign fire         = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      rdata_q     <= '0;
      payload_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (fire) begin
        out_valid_q <= 1'b1;
        rdata_q     <= opnd;
        payload_q   <= bus.in_payload;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (hazard_o && !flush && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_rdata   = rdata_q;
  assign bus.out_payload = payload_q;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_040729_idu_operand_stage.sv
// Directed bench for the operand-fetch stage.
// Each task drives one scenario and checks against hand-computed values.
module tb_ysyx_040729_idu_operand_stage;

  logic         clock;
  logic         reset;
  logic         flush;
  logic [1:0]   fwd_we;
  logic [9:0]   fwd_addr;
  logic [127:0] fwd_data;
  logic [1:0]   fwd_data_ok;
  logic         wb_we;
  logic [4:0]   wb_waddr;
  logic [63:0]  wb_wdata;
  logic         hazard_o;
  logic [31:0]  stall_cnt_o;

  int n_chk;
  int n_err;

  ysyx_040729_idu_operand_stage_if #(
    .DATA_WIDTH(64), .REG_ADDR_W(5),
    .NUM_READ(2), .PAYLOAD_W(32)
  ) bus ();

  ysyx_040729_idu_operand_stage #(
    .DATA_WIDTH(64), .REG_ADDR_W(5), .NUM_READ(2),
    .FWD_STAGES(2), .PAYLOAD_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .bus(bus),
    .fwd_we(fwd_we),
    .fwd_addr(fwd_addr),
    .fwd_data(fwd_data),
    .fwd_data_ok(fwd_data_ok),
    .wb_we(wb_we),
    .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata),
    .hazard_o(hazard_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush          = 1'b0;
    fwd_we         = '0;
    fwd_addr       = '0;
    fwd_data       = '0;
    fwd_data_ok    = '0;
    wb_we          = 1'b0;
    wb_waddr       = '0;
    wb_wdata       = '0;
    bus.in_valid   = 1'b0;
    bus.in_ren     = '0;
    bus.in_raddr   = '0;
    bus.in_payload = '0;
    bus.out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #12;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid got %b exp 0", bus.out_valid);
    end
    n_chk++;
    if (bus.out_rdata !== 128'd0) begin
      n_err++;
      $display("FAIL rst_rdata got %h exp 0", bus.out_rdata);
    end
    n_chk++;
    if (bus.out_payload !== 32'd0) begin
      n_err++;
      $display("FAIL rst_payload got %h exp 0", bus.out_payload);
    end
    n_chk++;
    if (stall_cnt_o !== 32'd0) begin
      n_err++;
      $display("FAIL rst_stall got %h exp 0", stall_cnt_o);
    end
    n_chk++;
    if (bus.in_ready !== 1'b1 || hazard_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready got %b/%b exp 1/0",
               bus.in_ready, hazard_o);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_wb_read();
    wb_we    = 1'b1;
    wb_waddr = 5'd5;
    wb_wdata = 64'h1234;
    tick();
    wb_we          = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b01;
    bus.in_raddr   = {5'd5, 5'd5};
    bus.in_payload = 32'hCAFE;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wb_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wb_valid got %b exp 1", bus.out_valid);
    end
    n_chk++;
    if (bus.out_rdata[63:0] !== 64'h1234) begin
      n_err++;
      $display("FAIL wb_p0 got %h exp 1234", bus.out_rdata[63:0]);
    end
    n_chk++;
    if (bus.out_rdata[127:64] !== 64'd0) begin
      n_err++;
      $display("FAIL ren_off got %h exp 0", bus.out_rdata[127:64]);
    end
    n_chk++;
    if (bus.out_payload !== 32'hCAFE) begin
      n_err++;
      $display("FAIL wb_payload got %h exp cafe", bus.out_payload);
    end
    wb_we          = 1'b1;
    wb_waddr       = 5'd9;
    wb_wdata       = 64'h99;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b11;
    bus.in_raddr   = {5'd5, 5'd9};
    bus.in_payload = 32'hBEEF;
    tick();
    wb_we        = 1'b0;
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.out_rdata !== {64'h1234, 64'h99}) begin
      n_err++;
      $display("FAIL wthru got %h exp 1234/99", bus.out_rdata);
    end
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_fwd_priority();
    fwd_we         = 2'b11;
    fwd_addr       = {5'd7, 5'd7};
    fwd_data       = {64'hBB, 64'hAA};
    fwd_data_ok    = 2'b11;
    wb_we          = 1'b1;
    wb_waddr       = 5'd7;
    wb_wdata       = 64'hCC;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b11;
    bus.in_raddr   = {5'd7, 5'd7};
    bus.in_payload = 32'd1;
    #1;
    n_chk++;
    if (hazard_o !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_haz got %b exp 0", hazard_o);
    end
    tick();
    n_chk++;
    if (bus.out_rdata !== {64'hAA, 64'hAA}) begin
      n_err++;
      $display("FAIL fwd_young got %h exp aa/aa", bus.out_rdata);
    end
    wb_we          = 1'b0;
    fwd_we         = 2'b10;
    bus.in_payload = 32'd2;
    tick();
    n_chk++;
    if (bus.out_rdata !== {64'hBB, 64'hBB}) begin
      n_err++;
      $display("FAIL fwd_old got %h exp bb/bb", bus.out_rdata);
    end
    fwd_we = 2'b00;
    tick();
    n_chk++;
    if (bus.out_rdata !== {64'hCC, 64'hCC}) begin
      n_err++;
      $display("FAIL fwd_rf got %h exp cc/cc", bus.out_rdata);
    end
    idle();
    tick();
  endtask

  task automatic test_hazard();
    fwd_we         = 2'b11;
    fwd_addr       = {5'd3, 5'd3};
    fwd_data       = {64'h55, 64'h66};
    fwd_data_ok    = 2'b10;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b01;
    bus.in_raddr   = {5'd0, 5'd3};
    bus.in_payload = 32'd3;
    #1;
    n_chk++;
    if (hazard_o !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL haz_on got %b/%b exp 1/0",
               hazard_o, bus.in_ready);
    end
    repeat (3) tick();
    n_chk++;
    if (stall_cnt_o !== 32'd3) begin
      n_err++;
      $display("FAIL haz_cnt got %0d exp 3", stall_cnt_o);
    end
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL haz_noissue got %b exp 0", bus.out_valid);
    end
    fwd_data    = {64'h55, 64'h77};
    fwd_data_ok = 2'b11;
    #1;
    n_chk++;
    if (hazard_o !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL haz_off got %b/%b exp 0/1",
               hazard_o, bus.in_ready);
    end
    tick();
    n_chk++;
    if (bus.out_rdata[63:0] !== 64'h77 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL haz_data got %h/%b exp 77/1",
               bus.out_rdata[63:0], bus.out_valid);
    end
    bus.in_valid = 1'b0;
    fwd_data_ok  = 2'b10;
    #1;
    n_chk++;
    if (hazard_o !== 1'b0) begin
      n_err++;
      $display("FAIL haz_novalid got %b exp 0", hazard_o);
    end
    tick();
    n_chk++;
    if (stall_cnt_o !== 32'd3) begin
      n_err++;
      $display("FAIL haz_cnthold got %0d exp 3", stall_cnt_o);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b01;
    bus.in_raddr   = {5'd0, 5'd5};
    bus.in_payload = 32'd1;
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_payload !== 32'd1) begin
      n_err++;
      $display("FAIL bp_load got %b/%h exp 1/1",
               bus.out_valid, bus.out_payload);
    end
    bus.in_raddr   = {5'd0, 5'd9};
    bus.in_payload = 32'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready[%0d] got %b exp 0", i, bus.in_ready);
      end
      tick();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_payload !== 32'd1 ||
          bus.out_rdata[63:0] !== 64'h1234) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got %b/%h/%h exp 1/1/1234", i,
                 bus.out_valid, bus.out_payload, bus.out_rdata[63:0]);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready got %b exp 1", bus.in_ready);
    end
    tick();
    n_chk++;
    if (bus.out_payload !== 32'd2 || bus.out_rdata[63:0] !== 64'h99) begin
      n_err++;
      $display("FAIL b2b_1 got %h/%h exp 2/99",
               bus.out_payload, bus.out_rdata[63:0]);
    end
    bus.in_raddr   = {5'd0, 5'd7};
    bus.in_payload = 32'd3;
    tick();
    n_chk++;
    if (bus.out_payload !== 32'd3 || bus.out_rdata[63:0] !== 64'hCC ||
        bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_2 got %h/%h/%b exp 3/cc/1",
               bus.out_payload, bus.out_rdata[63:0], bus.out_valid);
    end
    bus.in_valid = 1'b0;
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_x0();
    fwd_we         = 2'b11;
    fwd_addr       = {5'd0, 5'd0};
    fwd_data       = {64'hFF, 64'hFF};
    fwd_data_ok    = 2'b00;
    wb_we          = 1'b1;
    wb_waddr       = 5'd0;
    wb_wdata       = 64'hFF;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b11;
    bus.in_raddr   = {5'd0, 5'd0};
    bus.in_payload = 32'd4;
    #1;
    n_chk++;
    if (hazard_o !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL x0_haz got %b/%b exp 0/1",
               hazard_o, bus.in_ready);
    end
    tick();
    n_chk++;
    if (bus.out_rdata !== 128'd0 || bus.out_payload !== 32'd4) begin
      n_err++;
      $display("FAIL x0_data got %h/%h exp 0/4",
               bus.out_rdata, bus.out_payload);
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b01;
    bus.in_raddr   = {5'd0, 5'd5};
    bus.in_payload = 32'd5;
    tick();
    flush          = 1'b1;
    bus.out_ready  = 1'b1;
    bus.in_payload = 32'd6;
    fwd_we         = 2'b01;
    fwd_addr       = {5'd0, 5'd5};
    fwd_data_ok    = 2'b00;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fl_ready got %b exp 0", bus.in_ready);
    end
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.out_payload !== 32'd5) begin
      n_err++;
      $display("FAIL fl_kill got %b/%h exp 0/5",
               bus.out_valid, bus.out_payload);
    end
    n_chk++;
    if (stall_cnt_o !== 32'd3) begin
      n_err++;
      $display("FAIL fl_cnt got %0d exp 3", stall_cnt_o);
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    fwd_we        = 2'b01;
    fwd_addr      = {5'd0, 5'd3};
    fwd_data_ok   = 2'b00;
    bus.in_valid  = 1'b1;
    bus.in_ren    = 2'b01;
    bus.in_raddr  = {5'd0, 5'd3};
    tick();
    n_chk++;
    if (stall_cnt_o !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sat_reach got %h exp ffffffff", stall_cnt_o);
    end
    repeat (2) tick();
    n_chk++;
    if (stall_cnt_o !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sat_hold got %h exp ffffffff", stall_cnt_o);
    end
    idle();
    tick();
  endtask

  task automatic test_async_reset();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_ren     = 2'b01;
    bus.in_raddr   = {5'd0, 5'd5};
    bus.in_payload = 32'd7;
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ar_load got %b exp 1", bus.out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.out_payload !== 32'd0 ||
        bus.out_rdata !== 128'd0 || stall_cnt_o !== 32'd0) begin
      n_err++;
      $display("FAIL ar_clear got %b/%h/%h/%h exp 0/0/0/0",
               bus.out_valid, bus.out_payload,
               bus.out_rdata[63:0], stall_cnt_o);
    end
    @(negedge clock);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_rdata[63:0] !== 64'd0) begin
      n_err++;
      $display("FAIL ar_rf got %b/%h exp 1/0",
               bus.out_valid, bus.out_rdata[63:0]);
    end
    idle();
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    test_reset();
    test_wb_read();
    test_fwd_priority();
    test_hazard();
    test_back_to_back();
    test_x0();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
